// File: rtl/regfile_pkg.sv
// Shared types and default sizes for the multi-port register file and its users.
package regfile_pkg;

  localparam int unsigned XLEN_DEF = 32;
  localparam int unsigned NREG_DEF = 32;

  typedef enum logic [0:0] {
    StIdle,
    StClear
  } rf_state_t;

endpackage

// File: rtl/regfile_if.sv
// Read/write/clear bundle between the core pipeline (master) and the register file (slave).
interface regfile_if
  import regfile_pkg::*;
#(
  parameter int unsigned XLEN   = XLEN_DEF,
  parameter int unsigned NREG   = NREG_DEF,
  parameter int unsigned NREAD  = 2,
  parameter int unsigned NWRITE = 1
);
  localparam int unsigned AW = $clog2(NREG);

  logic                           clear_req;
  logic                           busy;
  logic [NWRITE-1:0]              we;
  logic [NWRITE-1:0][AW-1:0]      waddr;
  logic [NWRITE-1:0][XLEN-1:0]    wdata;
  logic [NREAD-1:0][AW-1:0]       raddr;
  logic [NREAD-1:0][XLEN-1:0]     rdata;

  modport master (
    output clear_req, we, waddr, wdata, raddr,
    input  busy, rdata
  );

  modport slave (
    input  clear_req, we, waddr, wdata, raddr,
    output busy, rdata
  );

endinterface

// File: rtl/rf_write_arbiter.sv
// Resolves write-port priority per register; the same result feeds the array and the bypass.
module rf_write_arbiter
  import regfile_pkg::*;
#(
  parameter int unsigned XLEN     = XLEN_DEF,
  parameter int unsigned NREG     = NREG_DEF,
  parameter int unsigned NREAD    = 2,
  parameter int unsigned NWRITE   = 1,
  parameter bit          ZERO_REG = 1'b1,
  parameter int unsigned AW       = $clog2(NREG)
) (
  input  logic [NWRITE-1:0]           we_i,
  input  logic [NWRITE-1:0][AW-1:0]   waddr_i,
  input  logic [NWRITE-1:0][XLEN-1:0] wdata_i,
  input  logic [NREAD-1:0][AW-1:0]    raddr_i,
  output logic [NREG-1:0]             reg_we_o,
  output logic [NREG-1:0][XLEN-1:0]   reg_wdata_o,
  output logic [NREAD-1:0]            byp_hit_o,
  output logic [NREAD-1:0][XLEN-1:0]  byp_data_o
);

  always_comb begin
    reg_we_o    = '0;
    reg_wdata_o = '0;
    for (int unsigned r = 0; r < NREG; r++) begin
      // Ascending scan: a later (higher-index) port overrides, so it wins the conflict.
      for (int unsigned p = 0; p < NWRITE; p++) begin
        if (we_i[p] && (waddr_i[p] == AW'(r)) && !(ZERO_REG && (r == 0))) begin
          reg_we_o[r]    = 1'b1;
          reg_wdata_o[r] = wdata_i[p];
        end
      end
    end
  end

  always_comb begin
    byp_hit_o  = '0;
    byp_data_o = '0;
    for (int unsigned r = 0; r < NREAD; r++) begin
      byp_hit_o[r]  = reg_we_o[raddr_i[r]];
      byp_data_o[r] = reg_wdata_o[raddr_i[r]];
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with same-cycle bypass and a sequential clear engine.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int unsigned XLEN     = XLEN_DEF,
  parameter int unsigned NREG     = NREG_DEF,
  parameter int unsigned NREAD    = 2,
  parameter int unsigned NWRITE   = 1,
  parameter bit          ZERO_REG = 1'b1,
  parameter bit          BYPASS   = 1'b1,
  parameter int unsigned AW       = $clog2(NREG)
) (
  input  logic     clk,
  input  logic     rst_n,
  regfile_if.slave bus
);

  rf_state_t                  state_q, state_d;
  logic [AW-1:0]              clr_idx_q, clr_idx_d;
  logic [XLEN-1:0]            rf_q [NREG];
  logic                       busy;
  logic [NWRITE-1:0]          we_gated;
  logic [NREG-1:0]            reg_we;
  logic [NREG-1:0][XLEN-1:0]  reg_wdata;
  logic [NREAD-1:0]           byp_hit;
  logic [NREAD-1:0][XLEN-1:0] byp_data;

  assign busy     = (state_q == StClear);
  assign bus.busy = busy;
  // Writes arriving while the clear runs are dropped, and never reach the bypass either.
  assign we_gated = busy ? '0 : bus.we;

  rf_write_arbiter #(
    .XLEN     (XLEN),
    .NREG     (NREG),
    .NREAD    (NREAD),
    .NWRITE   (NWRITE),
    .ZERO_REG (ZERO_REG),
    .AW       (AW)
  ) u_arb (
    .we_i        (we_gated),
    .waddr_i     (bus.waddr),
    .wdata_i     (bus.wdata),
    .raddr_i     (bus.raddr),
    .reg_we_o    (reg_we),
    .reg_wdata_o (reg_wdata),
    .byp_hit_o   (byp_hit),
    .byp_data_o  (byp_data)
  );

  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    unique case (state_q)
      StIdle: begin
        if (bus.clear_req) begin
          state_d   = StClear;
          clr_idx_d = '0;
        end
      end
      StClear: begin
        clr_idx_d = clr_idx_q + AW'(1);
        if (clr_idx_q == AW'(NREG - 1)) begin
          state_d   = StIdle;
          clr_idx_d = '0;
        end
      end
      default: begin
        state_d   = StClear;
        clr_idx_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StClear;
      clr_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
    end
  end

  // The array has no reset; the clear engine is what makes its contents defined.
  always_ff @(posedge clk) begin
    if (busy) begin
      rf_q[clr_idx_q] <= '0;
    end else begin
      for (int unsigned r = 0; r < NREG; r++) begin
        if (reg_we[r]) begin
          rf_q[r] <= reg_wdata[r];
        end
      end
    end
  end

  always_comb begin
    bus.rdata = '0;
    for (int unsigned r = 0; r < NREAD; r++) begin
      bus.rdata[r] = rf_q[bus.raddr[r]];
      if (BYPASS && byp_hit[r]) begin
        bus.rdata[r] = byp_data[r];
      end
      if (busy || (ZERO_REG && (bus.raddr[r] == '0))) begin
        bus.rdata[r] = '0;
      end
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Randomised bench for regfile_mp, comparing a bypass and a non-bypass instance to a reference model.
module tb_regfile_mp;
  import regfile_pkg::*;

  localparam int unsigned XLEN   = XLEN_DEF;
  localparam int unsigned NREG   = NREG_DEF;
  localparam int unsigned NREAD  = 2;
  localparam int unsigned NWRITE = 2;
  localparam int unsigned AW     = $clog2(NREG);

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   total = 0;
  int   bad   = 0;

  // Reference: architectural contents plus the number of clear cycles still outstanding.
  logic [XLEN-1:0] model_rf [NREG];
  int              clear_left = NREG;

  always #5 clk = ~clk;

  regfile_if #(.XLEN(XLEN), .NREG(NREG), .NREAD(NREAD), .NWRITE(NWRITE)) bus ();
  regfile_if #(.XLEN(XLEN), .NREG(NREG), .NREAD(NREAD), .NWRITE(NWRITE)) bus_nb ();

  assign bus_nb.clear_req = bus.clear_req;
  assign bus_nb.we        = bus.we;
  assign bus_nb.waddr     = bus.waddr;
  assign bus_nb.wdata     = bus.wdata;
  assign bus_nb.raddr     = bus.raddr;

  regfile_mp #(
    .XLEN(XLEN), .NREG(NREG), .NREAD(NREAD), .NWRITE(NWRITE),
    .ZERO_REG(1'b1), .BYPASS(1'b1)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  regfile_mp #(
    .XLEN(XLEN), .NREG(NREG), .NREAD(NREAD), .NWRITE(NWRITE),
    .ZERO_REG(1'b1), .BYPASS(1'b0)
  ) dut_nb (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_nb)
  );

  function automatic logic [XLEN-1:0] model_read(input logic [AW-1:0] a, input bit byp);
    logic [XLEN-1:0] v;
    if (clear_left > 0 || a == '0) return '0;
    v = model_rf[a];
    if (byp) begin
      for (int p = 0; p < NWRITE; p++) begin
        if (bus.we[p] && bus.waddr[p] == a) v = bus.wdata[p];
      end
    end
    return v;
  endfunction

  task automatic idle_inputs();
    bus.clear_req = 1'b0;
    bus.we        = '0;
    bus.waddr     = '0;
    bus.wdata     = '0;
  endtask

  // Checks outputs for the inputs currently driven, then advances one clock and the model.
  task automatic cycle();
    logic [XLEN-1:0] exp_b, exp_nb;
    logic            exp_busy;
    #1;
    exp_busy = (clear_left > 0);
    for (int r = 0; r < NREAD; r++) begin
      exp_b  = model_read(bus.raddr[r], 1'b1);
      exp_nb = model_read(bus.raddr[r], 1'b0);
      total++;
      if (bus.rdata[r] !== exp_b) begin
        bad++;
        $display("FAIL rdata_bypass port=%0d addr=%0d got=%h want=%h t=%0t",
                 r, bus.raddr[r], bus.rdata[r], exp_b, $time);
      end
      total++;
      if (bus_nb.rdata[r] !== exp_nb) begin
        bad++;
        $display("FAIL rdata_nobypass port=%0d addr=%0d got=%h want=%h t=%0t",
                 r, bus.raddr[r], bus_nb.rdata[r], exp_nb, $time);
      end
    end
    total++;
    if (bus.busy !== exp_busy || bus_nb.busy !== exp_busy) begin
      bad++;
      $display("FAIL busy got=%b/%b want=%b t=%0t", bus.busy, bus_nb.busy, exp_busy, $time);
    end
    @(posedge clk);
    if (!rst_n) begin
      clear_left = NREG;
    end else if (clear_left > 0) begin
      clear_left--;
      if (clear_left == 0) foreach (model_rf[i]) model_rf[i] = '0;
    end else begin
      for (int p = 0; p < NWRITE; p++) begin
        if (bus.we[p] && bus.waddr[p] != '0) model_rf[bus.waddr[p]] = bus.wdata[p];
      end
      if (bus.clear_req) clear_left = NREG;
    end
    @(negedge clk);
  endtask

  task automatic count_busy(input string name);
    int n = 0;
    while (bus.busy === 1'b1 && n < 100) begin
      cycle();
      n++;
    end
    total++;
    if (n != NREG) begin
      bad++;
      $display("FAIL %s busy_cycles got=%0d want=%0d", name, n, NREG);
    end
  endtask

  task automatic read_all();
    idle_inputs();
    for (int a = 0; a < NREG; a++) begin
      bus.raddr[0] = AW'(a);
      bus.raddr[1] = AW'(NREG - 1 - a);
      cycle();
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    bus.raddr = '0;
    #2 rst_n = 1'b0;
    clear_left = NREG;
    @(negedge clk);
    repeat (3) cycle();
    rst_n = 1'b1;
    count_busy("reset");
    bus.raddr[0] = AW'(5);
    bus.raddr[1] = AW'(5);
    cycle();
  endtask

  task automatic test_basic();
    idle_inputs();
    bus.we[0]    = 1'b1;
    bus.waddr[0] = AW'(3);
    bus.wdata[0] = 32'hDEAD_BEEF;
    bus.raddr[0] = AW'(3);
    bus.raddr[1] = AW'(3);
    cycle();
    idle_inputs();
    cycle();
  endtask

  task automatic test_zero_reg();
    idle_inputs();
    bus.we[0]    = 1'b1;
    bus.waddr[0] = '0;
    bus.wdata[0] = 32'h0000_1234;
    bus.raddr    = '0;
    cycle();
    idle_inputs();
    cycle();
  endtask

  task automatic test_conflict();
    idle_inputs();
    bus.we       = '1;
    bus.waddr[0] = AW'(7);
    bus.waddr[1] = AW'(7);
    bus.wdata[0] = 32'h11;
    bus.wdata[1] = 32'h22;
    bus.raddr[0] = AW'(7);
    bus.raddr[1] = AW'(7);
    cycle();
    idle_inputs();
    cycle();
  endtask

  task automatic test_clear();
    idle_inputs();
    for (int a = 1; a < NREG; a++) begin
      bus.we[0]    = 1'b1;
      bus.waddr[0] = AW'(a);
      bus.wdata[0] = XLEN'(a);
      bus.raddr[0] = AW'(a);
      bus.raddr[1] = AW'(a - 1);
      cycle();
    end
    idle_inputs();
    bus.clear_req = 1'b1;
    cycle();
    bus.clear_req = 1'b0;
    bus.we[1]     = 1'b1;
    bus.waddr[1]  = AW'(9);
    bus.wdata[1]  = 32'hCAFE_F00D;
    bus.raddr[0]  = AW'(9);
    count_busy("clear");
    read_all();
  endtask

  task automatic test_reset_mid_clear();
    read_all();
    bus.clear_req = 1'b1;
    cycle();
    bus.clear_req = 1'b0;
    repeat (10) cycle();
    rst_n = 1'b0;
    clear_left = NREG;
    cycle();
    cycle();
    rst_n = 1'b1;
    count_busy("reset_mid_clear");
    read_all();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      for (int p = 0; p < NWRITE; p++) begin
        bus.we[p]    = 1'($urandom_range(0, 1));
        bus.waddr[p] = ($urandom_range(0, 1) == 1) ? AW'($urandom_range(0, 3)) : AW'($urandom);
        bus.wdata[p] = $urandom;
      end
      for (int r = 0; r < NREAD; r++) begin
        bus.raddr[r] = ($urandom_range(0, 1) == 1) ? AW'($urandom_range(0, 3)) : AW'($urandom);
      end
      bus.clear_req = ($urandom_range(0, 99) == 0);
      cycle();
    end
    idle_inputs();
    read_all();
  endtask

  initial begin
    foreach (model_rf[i]) model_rf[i] = '0;
    test_reset();
    test_basic();
    test_zero_reg();
    test_conflict();
    test_clear();
    test_reset_mid_clear();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port integer register file; next generation of the single-write/dual-read core register file.
- Sits in the core's decode/writeback stages. Supplies NREAD combinational read ports and accepts NWRITE synchronous write ports.
- Adds same-cycle write-to-read bypass, deterministic write-port priority and a sequential clear engine that zeroes the array after reset or on request.

Parameters:
- XLEN, 32, data width in bits.
- NREG, 32, number of architectural registers (power of two, >=2).
- NREAD, 2, number of read ports (>=1).
- NWRITE, 1, number of write ports (1..4).
- ZERO_REG, 1, 1 = register 0 reads 0 and ignores writes.
- BYPASS, 1, 1 = a read of a register being written this cycle returns the new data.
- AW, $clog2(NREG), address width (derived; do not override).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- clear_req  in  1  single-cycle pulse; starts a full array clear.
- busy  out  1  high while the clear engine runs.
- we  in  NWRITE  per-port write enable.
- waddr  in  NWRITE x AW  per-port write address.
- wdata  in  NWRITE x XLEN  per-port write data.
- raddr  in  NREAD x AW  per-port read address.
- rdata  out  NREAD x XLEN  per-port read data (combinational).

Behaviour:
- Reset and clock: one clock, clk; reset rst_n is asynchronous, active-low.
- State machine: IDLE, CLEAR.
  - rst_n low forces CLEAR with clr_idx=0 and busy=1. busy's reset value is 1.
  - The array itself is not reset; contents are undefined until the clear completes.
- CLEAR: each cycle writes 0 to rf[clr_idx], then clr_idx++.
  - When clr_idx==NREG-1 is written, go to IDLE; busy drops the next cycle.
  - A clear takes exactly NREG cycles after reset deasserts.
- IDLE, clear_req=1: enter CLEAR next cycle with clr_idx=0. busy rises one cycle after the request.
- clear_req during CLEAR: ignored; the clear continues without restarting.
- rst_n asserted mid-clear: clr_idx returns to 0 and the clear restarts after release.
- While busy=1:
  - All we are ignored; those writes are dropped with no buffering.
  - All rdata = 0.
- Write (IDLE), at posedge clk:
  - For each port p with we[p]=1, rf[waddr[p]] <= wdata[p].
  - If ZERO_REG=1 and waddr[p]==0, that write is discarded.
- Write conflict: several enabled ports with the same waddr → the highest-index port wins, for both array update and bypass.
- Read is combinational, zero latency: rdata[r] = rf[raddr[r]].
  - If ZERO_REG=1 and raddr[r]==0, rdata[r] = 0 regardless of array content.
  - If BYPASS=1 and some port p has we[p]=1, waddr[p]==raddr[r] and the write is not discarded, rdata[r] = wdata of the winning port.
  - If BYPASS=0, the read returns the old value; the new value is visible from the next cycle.
- Address range: addresses are exactly AW bits, so no out-of-range addresses exist.
- No X propagation: rdata must never be X once busy has been low for one cycle.

Decomposition:
- Shared package regfile_pkg:
  - typedef rf_state_t {IDLE, CLEAR}.
  - Default constants XLEN_DEF=32 and NREG_DEF=32, reused by core top and testbenches.
- Sub-module rf_write_arbiter (combinational):
  - Resolves per-address winning write port and the discard for register 0.
  - Outputs per-register write enable/data for the array and a per-read-port bypass hit/data.
  - Shared by the write path and the bypass path so both always agree on priority.
- The clear FSM and its clr_idx counter live in regfile_mp.

Test Plan:
- Reset then wait: rst_n low 3 cycles, release → busy=1 for exactly NREG=32 cycles; afterwards raddr[0..1]=5 → rdata=0.
- Basic write/read: we[0]=1, waddr=3, wdata=0xDEADBEEF; next cycle raddr[0]=3 → 0xDEADBEEF.
  - Same cycle, BYPASS=1: rdata=0xDEADBEEF. BYPASS=0: rdata=0.
- Register 0: write 0x1234 to addr 0 with ZERO_REG=1 → reads 0 in the same and next cycle, on all read ports.
- Write conflict (NWRITE=2): both ports write addr 7, port0=0x11 and port1=0x22 → same-cycle bypass and next-cycle read both return 0x22.
- Clear request: fill regs 1..31 with their index, pulse clear_req.
  - busy=1 for 32 cycles; a write to addr 9 during busy is dropped.
  - After busy falls, every register reads 0.
- Reset mid-clear: assert rst_n at clr_idx=10 → after release, busy stays high for a full 32 cycles; afterwards all registers read 0.
